// File: rtl/multicycle_controller.sv
// Sequencing controller for the multicycle RV32I core: Moore FSM plus combinational
// ALU, immediate-select and branch-condition decoders sharing one ALU and one memory port.
module multicycle_controller #(
    parameter logic MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       Sign,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       IllegalInstr
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic       mem_rdy;
    logic [2:0] alu_dec;
    logic       alu_dec_ill;
    logic       br_taken;
    logic       br_ill;
    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

    assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

    // Only register-register adds with Instr[30] set subtract; addi never does.
    always_comb begin
        alu_dec     = 3'b000;
        alu_dec_ill = 1'b0;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        br_ill   = 1'b0;
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = ~Zero;
            3'b100:  br_taken = Sign;
            3'b101:  br_taken = ~Sign;
            default: br_ill = 1'b1;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d      = S_FETCH;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUControl   = 3'b000;
        IllegalInstr = 1'b0;
        pc_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ResultSrc  = 2'b10;
                ALUSrcB    = 2'b10;
                ir_write_c = mem_rdy;
                pc_write_c = mem_rdy;
                state_d    = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default:      IllegalInstr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                state_d     = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA      = 2'b10;
                ALUControl   = alu_dec;
                IllegalInstr = alu_dec_ill;
                state_d      = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA      = 2'b10;
                ALUSrcB      = 2'b01;
                ALUControl   = alu_dec;
                IllegalInstr = alu_dec_ill;
                state_d      = S_ALUWB;
            end
            S_ALUWB: reg_write_c = 1'b1;
            S_BRANCH: begin
                ALUSrcA      = 2'b10;
                ALUControl   = 3'b001;
                pc_write_c   = br_taken;
                IllegalInstr = br_ill;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are cut asynchronously so an aborted store never completes.
    assign PCWrite  = pc_write_c  & ~areset;
    assign IRWrite  = ir_write_c  & ~areset;
    assign MemWrite = mem_write_c & ~areset;
    assign RegWrite = reg_write_c & ~areset;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors pushed by the
// stimulus process, popped and compared by an independent monitor on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7 = 1'b0;
    logic       Zero = 1'b0;
    logic       Sign = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .areset(areset), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Sign(Sign), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .IllegalInstr(IllegalInstr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [16:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    bit   done     = 1'b0;

    logic [6:0] p_op = 7'b0110011;
    logic [2:0] p_f3 = 3'b000;
    logic       p_f7 = 1'b0;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, IllegalInstr}
    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic rw, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, ill};
    endfunction

    function automatic logic [16:0] e_fetch(input logic [1:0] imm, input logic rdy);
        return v(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0, 1'b0);
    endfunction

    function automatic logic [16:0] e_decode(input logic [1:0] imm, input logic ill);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0, ill);
    endfunction

    function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
        return v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1, 1'b0);
    endfunction

    task automatic cyc(input string nm, input logic rst, input logic mr, input logic z,
                       input logic s, input logic [16:0] e);
        exp_t t;
        @(posedge clk);
        #1;
        areset   = rst;
        MemReady = mr;
        Zero     = z;
        Sign     = s;
        op       = p_op;
        funct3   = p_f3;
        funct7   = p_f7;
        t.name   = nm;
        t.exp    = e;
        q.push_back(t);
    endtask

    task automatic set_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7);
        p_op = o;
        p_f3 = f3;
        p_f7 = f7;
        $display("issue %s op=%b funct3=%b funct7=%b", nm, o, f3, f7);
    endtask

    task automatic do_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [1:0] sb, input logic [2:0] alu,
                          input logic ill);
        set_instr(nm, o, f3, f7);
        cyc({nm, "_fetch"},  1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b00, 1'b1));
        cyc({nm, "_decode"}, 1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b00, 1'b0));
        cyc({nm, "_exec"},   1'b0, 1'b1, 1'b0, 1'b0,
            v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, 2'b00, alu, 1'b0, ill));
        cyc({nm, "_aluwb"},  1'b0, 1'b1, 1'b0, 1'b0, e_aluwb(2'b00));
    endtask

    task automatic do_branch(input string nm, input logic [2:0] f3, input logic z,
                             input logic s, input logic taken, input logic ill);
        set_instr(nm, 7'b1100011, f3, 1'b0);
        cyc({nm, "_fetch"},  1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b10, 1'b1));
        cyc({nm, "_decode"}, 1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b10, 1'b0));
        cyc({nm, "_branch"}, 1'b0, 1'b1, z, s,
            v(taken, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0, ill));
    endtask

    initial begin
        cyc("reset0", 1'b1, 1'b1, 1'b0, 1'b0, e_fetch(2'b00, 1'b0));
        cyc("reset1", 1'b1, 1'b1, 1'b0, 1'b0, e_fetch(2'b00, 1'b0));

        do_alu("add",  7'b0110011, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0);
        do_alu("sub",  7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001, 1'b0);
        do_alu("addi", 7'b0010011, 3'b000, 1'b1, 2'b01, 3'b000, 1'b0);
        do_alu("slt",  7'b0110011, 3'b010, 1'b0, 2'b00, 3'b101, 1'b0);
        do_alu("ori",  7'b0010011, 3'b110, 1'b0, 2'b01, 3'b011, 1'b0);
        do_alu("and",  7'b0110011, 3'b111, 1'b0, 2'b00, 3'b010, 1'b0);
        do_alu("sll",  7'b0110011, 3'b001, 1'b0, 2'b00, 3'b000, 1'b1);

        set_instr("lw", 7'b0000011, 3'b010, 1'b0);
        cyc("lw_fetch_wait", 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(2'b00, 1'b0));
        cyc("lw_fetch",      1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b00, 1'b1));
        cyc("lw_decode",     1'b0, 1'b0, 1'b0, 1'b0, e_decode(2'b00, 1'b0));
        cyc("lw_memadr",     1'b0, 1'b0, 1'b0, 1'b0,
            v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw_memread%0d", i), 1'b0, (i == 2), 1'b0, 1'b0,
                v(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0));
        cyc("lw_memwb", 1'b0, 1'b1, 1'b0, 1'b0,
            v(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0));

        set_instr("sw", 7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch",  1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b01, 1'b1));
        cyc("sw_decode", 1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b01, 1'b0));
        cyc("sw_memadr", 1'b0, 1'b1, 1'b0, 1'b0,
            v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0));
        cyc("sw_memwrite", 1'b0, 1'b1, 1'b0, 1'b0,
            v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0));

        do_branch("beq_taken", 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        do_branch("bge_not",   3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
        do_branch("bne_taken", 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        do_branch("blt_not",   3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
        do_branch("bad_br",    3'b010, 1'b1, 1'b1, 1'b0, 1'b1);

        set_instr("jal", 7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",  1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b11, 1'b1));
        cyc("jal_decode", 1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b11, 1'b0));
        cyc("jal_jal",    1'b0, 1'b1, 1'b0, 1'b0,
            v(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0, 1'b0));
        cyc("jal_aluwb",  1'b0, 1'b1, 1'b0, 1'b0, e_aluwb(2'b11));

        set_instr("illegal", 7'b1111111, 3'b000, 1'b0);
        cyc("ill_fetch",  1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b00, 1'b1));
        cyc("ill_decode", 1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b00, 1'b1));

        set_instr("sw_abort", 7'b0100011, 3'b010, 1'b0);
        cyc("swa_fetch",  1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b01, 1'b1));
        cyc("swa_decode", 1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b01, 1'b0));
        cyc("swa_memadr", 1'b0, 1'b0, 1'b0, 1'b0,
            v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0));
        cyc("swa_memwrite", 1'b0, 1'b0, 1'b0, 1'b0,
            v(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0));
        cyc("swa_reset",    1'b1, 1'b0, 1'b0, 1'b0, e_fetch(2'b01, 1'b0));
        cyc("swa_reset_mr", 1'b1, 1'b1, 1'b0, 1'b0, e_fetch(2'b01, 1'b0));
        cyc("swa_rel_wait", 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(2'b01, 1'b0));
        cyc("swa_rel_fetch", 1'b0, 1'b1, 1'b0, 1'b0, e_fetch(2'b01, 1'b1));
        cyc("swa_decode2",  1'b0, 1'b1, 1'b0, 1'b0, e_decode(2'b01, 1'b0));

        done = 1'b1;
    end

    initial begin
        exp_t t;
        logic [16:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                t   = q.pop_front();
                act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       ImmSrc, ALUControl, RegWrite, IllegalInstr};
                n_checks++;
                if (act !== t.exp) begin
                    n_fails++;
                    $display("FAIL %s: got %b expected %b", t.name, act, t.exp);
                end
            end
            if (done) break;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
